// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences compute and write-back phases of the
// systolic datapath over a runtime-programmable number of matrix sets.
module systolic_seq_ctrl #(
    parameter int ARRAY_SIZE     = 8,
    parameter int NUM_BANKS      = 3,
    parameter int ALU_LATENCY    = 3*ARRAY_SIZE-1,
    parameter int CYCLE_BITS     = 9,
    parameter int MATRIX_BITS    = 6,
    parameter int ADDR_MAX       = 127,
    parameter int ADDR_WIDTH_MIN = 7,
    parameter int SETS_BITS      = 5,
    parameter int BANK_BITS      = 2
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      tpu_start,
    input  logic [SETS_BITS-1:0]      num_sets,
    input  logic                      abort,
    input  logic                      wr_ready,
    output logic                      busy,
    output logic                      alu_start,
    output logic [CYCLE_BITS-1:0]     cycle_num,
    output logic [ADDR_WIDTH_MIN-1:0] addr_serial_num,
    output logic [MATRIX_BITS-1:0]    matrix_index,
    output logic                      sram_write_enable,
    output logic [BANK_BITS-1:0]      data_set,
    output logic                      cfg_err,
    output logic                      tpu_done
);

    typedef enum logic [1:0] {IDLE, COMPUTE, WRITE, DONE} state_t;

    localparam logic [CYCLE_BITS-1:0]     CYC_LAST  = CYCLE_BITS'(ALU_LATENCY-1);
    localparam logic [CYCLE_BITS-1:0]     CYC_HOLD  = CYCLE_BITS'(ARRAY_SIZE);
    localparam logic [MATRIX_BITS-1:0]    ROW_LAST  = MATRIX_BITS'(2*ARRAY_SIZE-2);
    localparam logic [BANK_BITS-1:0]      BANK_LAST = BANK_BITS'(NUM_BANKS-1);
    localparam logic [ADDR_WIDTH_MIN-1:0] STEP      = ADDR_WIDTH_MIN'(ARRAY_SIZE);

    state_t                    state, state_d;
    logic [SETS_BITS-1:0]      set_q, set_d, last_q, last_d;
    logic [ADDR_WIDTH_MIN-1:0] base_q, base_d, addr_d;
    logic [CYCLE_BITS-1:0]     cyc_d;
    logic [MATRIX_BITS-1:0]    mi_d;
    logic [BANK_BITS-1:0]      bank_d;
    logic                      err_d;
    logic [31:0]               need;
    logic                      over;

    // Rows needed by the request; the last row must not pass ADDR_MAX.
    assign need = 32'(num_sets) * 32'(ARRAY_SIZE);
    assign over = need > 32'(ADDR_MAX + 1);

    // The writer accepts a row in the same cycle it raises wr_ready, so
    // the strobe is gated straight from it rather than delayed a cycle.
    assign sram_write_enable = (state == WRITE) && wr_ready;

    // Next-state and next-counter logic; abort overrides every transition.
    always_comb begin
        state_d = state;
        set_d   = set_q;
        last_d  = last_q;
        base_d  = base_q;
        cyc_d   = cycle_num;
        mi_d    = matrix_index;
        bank_d  = data_set;
        err_d   = 1'b0;
        addr_d  = '0;
        if (abort && state != IDLE) begin
            state_d = IDLE;
            set_d   = '0;
            last_d  = '0;
            base_d  = '0;
            cyc_d   = '0;
            mi_d    = '0;
            bank_d  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tpu_start && !abort) begin
                        set_d  = '0;
                        last_d = num_sets - SETS_BITS'(1);
                        base_d = '0;
                        cyc_d  = '0;
                        mi_d   = '0;
                        bank_d = '0;
                        if (num_sets == '0) begin
                            state_d = DONE;
                        end else if (over) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    if (cycle_num == CYC_LAST) begin
                        state_d = WRITE;
                        cyc_d   = '0;
                        mi_d    = '0;
                    end else begin
                        cyc_d = cycle_num + CYCLE_BITS'(1);
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        if (matrix_index == ROW_LAST) begin
                            mi_d = '0;
                            if (set_q == last_q) begin
                                state_d = DONE;
                            end else begin
                                state_d = COMPUTE;
                                set_d   = set_q + SETS_BITS'(1);
                                base_d  = base_q + STEP;
                                cyc_d   = '0;
                                bank_d  = (data_set == BANK_LAST) ? '0
                                        : data_set + BANK_BITS'(1);
                            end
                        end else begin
                            mi_d = matrix_index + MATRIX_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (state_d == COMPUTE) begin
            addr_d = base_d + ((cyc_d < CYC_HOLD) ? ADDR_WIDTH_MIN'(cyc_d)
                                                  : STEP - ADDR_WIDTH_MIN'(1));
        end
    end

    // State, counters and registered outputs; srst clears everything.
    always_ff @(posedge clk) begin
        if (srst) begin
            state           <= IDLE;
            set_q           <= '0;
            last_q          <= '0;
            base_q          <= '0;
            cycle_num       <= '0;
            matrix_index    <= '0;
            data_set        <= '0;
            addr_serial_num <= '0;
            busy            <= 1'b0;
            alu_start       <= 1'b0;
            tpu_done        <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            state           <= state_d;
            set_q           <= set_d;
            last_q          <= last_d;
            base_q          <= base_d;
            cycle_num       <= cyc_d;
            matrix_index    <= mi_d;
            data_set        <= bank_d;
            addr_serial_num <= addr_d;
            busy            <= state_d != IDLE;
            alu_start       <= state_d == COMPUTE;
            tpu_done        <= state_d == DONE;
            cfg_err         <= err_d;
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: timeline model feeds scoreboard queues that a
// negedge monitor drains against the sequencer outputs.
module tb_systolic_seq_ctrl;

    localparam int N    = 8;
    localparam int NB   = 3;
    localparam int LAT  = 3*N-1;
    localparam int ROWS = 2*N-1;
    localparam int AMAX = 127;
    localparam int PW   = 32768;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       tpu_start = 1'b0;
    logic [4:0] num_sets = '0;
    logic       abort = 1'b0;
    logic       wr_ready = 1'b1;
    logic       busy, alu_start, sram_write_enable, cfg_err, tpu_done;
    logic [8:0] cycle_num;
    logic [6:0] addr_serial_num;
    logic [5:0] matrix_index;
    logic [1:0] data_set;

    systolic_seq_ctrl dut (
        .clk(clk), .srst(srst), .tpu_start(tpu_start),
        .num_sets(num_sets), .abort(abort), .wr_ready(wr_ready),
        .busy(busy), .alu_start(alu_start), .cycle_num(cycle_num),
        .addr_serial_num(addr_serial_num), .matrix_index(matrix_index),
        .sram_write_enable(sram_write_enable), .data_set(data_set),
        .cfg_err(cfg_err), .tpu_done(tpu_done)
    );

    typedef struct {int c; int a; int b;} ev_t;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   wr_pat [PW];
    ev_t  cq[$];
    ev_t  wq[$];
    ev_t  dq[$];

    initial forever begin
        #5 clk = 1'b1;
        cyc++;
        #5 clk = 1'b0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // wr_ready for cycle n comes from a pre-planned pattern
    always @(posedge clk) begin
        #1 wr_ready = wr_pat[cyc % PW];
    end

    function automatic void chk(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, exp);
        end
    endfunction

    function automatic ev_t mk(int c, int a, int b);
        ev_t e;
        e.c = c; e.a = a; e.b = b;
        return e;
    endfunction

    // Expected event timeline for a start accepted in cycle t.
    function automatic void model(int t, int s);
        int c;
        bit err;
        err = (s > 0) && (s*N - 1 > AMAX);
        busy_lo = t + 1;
        if (s == 0 || err) begin
            dq.push_back(mk(t + 1, int'(err), 0));
            busy_hi = t + 1;
            return;
        end
        c = t + 1;
        for (int k = 0; k < s; k++) begin
            for (int i = 0; i < LAT; i++)
                cq.push_back(mk(c + i, i, k*N + ((i < N) ? i : N-1)));
            c += LAT;
            for (int m = 0; m < ROWS; m++) begin
                while (!wr_pat[c % PW] && c < t + 20000) c++;
                wq.push_back(mk(c, m, k % NB));
                c++;
            end
        end
        dq.push_back(mk(c, 0, 0));
        busy_hi = c;
    endfunction

    function automatic void flush(int k);
        while (cq.size() > 0 && cq[$].c > k) void'(cq.pop_back());
        while (wq.size() > 0 && wq[$].c > k) void'(wq.pop_back());
        while (dq.size() > 0 && dq[$].c > k) void'(dq.pop_back());
        busy_hi = k;
    endfunction

    function automatic void check_zero(string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_alu_start"}, int'(alu_start), 0);
        chk({tag, "_cycle_num"}, int'(cycle_num), 0);
        chk({tag, "_addr"}, int'(addr_serial_num), 0);
        chk({tag, "_matrix_index"}, int'(matrix_index), 0);
        chk({tag, "_we"}, int'(sram_write_enable), 0);
        chk({tag, "_data_set"}, int'(data_set), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_tpu_done"}, int'(tpu_done), 0);
    endfunction

    // Monitor: pop an expectation whenever the DUT presents an output
    always @(negedge clk) begin : mon
        ev_t e;
        if (mon_en) begin
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (alu_start) begin
                if (cq.size() == 0) chk("alu_spurious", 1, 0);
                else begin
                    e = cq.pop_front();
                    chk("alu_cycle", cyc, e.c);
                    chk("cycle_num", int'(cycle_num), e.a);
                    chk("addr_serial_num", int'(addr_serial_num), e.b);
                end
            end else if (cq.size() > 0 && cq[0].c <= cyc) begin
                void'(cq.pop_front());
                chk("alu_missing", 0, 1);
            end
            if (sram_write_enable) begin
                if (wq.size() == 0) chk("we_spurious", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("we_cycle", cyc, e.c);
                    chk("matrix_index", int'(matrix_index), e.a);
                    chk("data_set", int'(data_set), e.b);
                end
            end else if (wq.size() > 0 && wq[0].c <= cyc) begin
                void'(wq.pop_front());
                chk("we_missing", 0, 1);
            end
            if (tpu_done) begin
                if (dq.size() == 0) chk("done_spurious", 1, 0);
                else begin
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.c);
                    chk("cfg_err", int'(cfg_err), e.a);
                end
            end else begin
                chk("cfg_err_idle", int'(cfg_err), 0);
                if (dq.size() > 0 && dq[0].c <= cyc) begin
                    void'(dq.pop_front());
                    chk("done_missing", 0, 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(int c);
        while (cyc < c) step();
    endtask

    task automatic start_txn(int s);
        tpu_start = 1'b1;
        num_sets  = 5'(s);
        model(cyc, s);
        step();
        tpu_start = 1'b0;
        num_sets  = 5'($urandom);
    endtask

    task automatic stray_start();
        tpu_start = 1'b1;
        num_sets  = 5'($urandom_range(1, 3));
        step();
        tpu_start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        flush(cyc);
        step();
        abort = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((cq.size() + wq.size() + dq.size()) > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((cq.size() + wq.size() + dq.size()) > 0) begin
            chk("timeout", 0, 1);
            cq.delete(); wq.delete(); dq.delete();
        end
        step();
        step();
    endtask

    task automatic fill_ready(int from, int len, int pct);
        for (int i = from; i < from + len; i++)
            wr_pat[i % PW] = ($urandom_range(0, 99) < pct);
    endtask

    initial begin
        int t, s, k;
        for (int i = 0; i < PW; i++) wr_pat[i] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        srst = 1'b0;
        mon_en = 1'b1;
        step();

        t = cyc; start_txn(1); wait_idle(200);

        t = cyc; start_txn(4);
        goto(t + 5); stray_start();
        wait_idle(400);

        t = cyc;
        for (int i = 29; i < 32; i++) wr_pat[(t + i) % PW] = 1'b0;
        start_txn(1); wait_idle(200);

        t = cyc; start_txn(16); wait_idle(1000);
        t = cyc; start_txn(17); wait_idle(50);
        t = cyc; start_txn(0); wait_idle(50);

        t = cyc; start_txn(2);
        goto(t + 10); do_abort();
        goto(t + 12); start_txn(2); wait_idle(300);

        t = cyc; start_txn(1);
        goto(t + 30);
        srst = 1'b1;
        flush(cyc);
        step();
        @(negedge clk);
        check_zero("srst");
        srst = 1'b0;
        step();

        for (int r = 0; r < 8; r++) begin
            t = cyc;
            fill_ready(t + 1, 2000, 70);
            s = $urandom_range(0, 18);
            start_txn(s);
            if (s >= 1 && s <= 16) begin
                goto(t + 3); stray_start();
                if ($urandom_range(0, 2) == 0) begin
                    k = t + 4 + $urandom_range(0, 38*s - 4);
                    goto(k); do_abort();
                end
            end
            wait_idle(3000);
        end
        for (int i = 0; i < PW; i++) wr_pat[i] = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Parametrised sequencer for the systolic datapath that runs a runtime-programmable number of matrix sets back to back. It has a start/busy/done handshake, write-side backpressure, round-robin output-bank selection across a configurable bank count, abort, and configuration-error detection. It sits between the host start logic and the address generator, systolic array and output writer. It drives their `addr_serial_num`, `alu_start`, `cycle_num`, `matrix_index`, write-enable and bank-select inputs.

## Interface
- ARRAY_SIZE, 8, systolic array dimension N
- NUM_BANKS, 3, number of output SRAM banks written round-robin (≥1)
- ALU_LATENCY, 3*ARRAY_SIZE-1, compute cycles per set
- CYCLE_BITS, 9, width of cycle_num (must hold ALU_LATENCY-1)
- MATRIX_BITS, 6, width of matrix_index (must hold 2*ARRAY_SIZE-2)
- ADDR_MAX, 127, highest legal input SRAM row address
- ADDR_WIDTH_MIN, 7, width of addr_serial_num
- SETS_BITS, 5, width of num_sets
- BANK_BITS, 2, width of data_set (must hold NUM_BANKS-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- srst  in  1  synchronous active-high reset
- tpu_start  in  1  start request, sampled only in IDLE
- num_sets  in  SETS_BITS  matrix sets to process, sampled with tpu_start
- abort  in  1  synchronous abort
- wr_ready  in  1  output writer can accept a row this cycle
- busy  out  1  high in every state except IDLE
- alu_start  out  1  high during COMPUTE
- cycle_num  out  CYCLE_BITS  compute cycle within set
- addr_serial_num  out  ADDR_WIDTH_MIN  input SRAM row index
- matrix_index  out  MATRIX_BITS  output diagonal row being written
- sram_write_enable  out  1  write strobe for current row
- data_set  out  BANK_BITS  target bank, = set index mod NUM_BANKS
- cfg_err  out  1  one-cycle pulse when the requested sets exceed the address range
- tpu_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, COMPUTE, WRITE, DONE.
- IDLE + tpu_start, legal config → COMPUTE, set=0, cycle_num=0.
- IDLE + tpu_start, num_sets=0 → DONE. No compute is issued.
- IDLE + tpu_start, num_sets*ARRAY_SIZE-1 > ADDR_MAX → DONE, with cfg_err pulsed in the DONE cycle.
- COMPUTE: alu_start=1 and cycle_num counts 0..ALU_LATENCY-1.
  - addr_serial_num = set*ARRAY_SIZE + cycle_num while cycle_num < ARRAY_SIZE, then holds set*ARRAY_SIZE+ARRAY_SIZE-1.
  - Leaves to WRITE after cycle_num = ALU_LATENCY-1.
- WRITE: matrix_index counts 0..2*ARRAY_SIZE-2.
  - sram_write_enable = wr_ready.
  - matrix_index advances only on cycles with wr_ready=1.
  - After the row 2*ARRAY_SIZE-2 write is accepted: next set → COMPUTE (set+1, cycle_num=0, data_set advances mod NUM_BANKS); last set → DONE.
- DONE: tpu_done=1 for one cycle, then IDLE.
- tpu_start while busy is ignored. num_sets is latched at start; later changes have no effect.
- abort, in any non-IDLE state, → IDLE next cycle. No tpu_done is issued and counters are cleared.
- srst has priority over abort. abort has priority over all transitions.

## Timing
- All outputs are registered. Reset value of every output is 0, state=IDLE.
- Start accepted at cycle t:
  - COMPUTE occupies t+1..t+ALU_LATENCY.
  - WRITE begins at t+ALU_LATENCY+1.
- With no stalls, each set takes ALU_LATENCY + 2*ARRAY_SIZE-1 cycles.
- tpu_done fires at t+1+S*(per-set cycles), where S = num_sets. A config error or S=0 gives tpu_done at t+1.
- busy rises at t+1 and falls the cycle after tpu_done (or the cycle after abort).
- data_set and matrix_index are valid in the same cycle as sram_write_enable.
- srst mid-operation → all outputs 0 on the next edge; any in-flight set is discarded.

## Test plan
Defaults apply (N=8, ALU_LATENCY=23, 15 write rows, 38 cycles per set).
- Single set: start at cycle 0, num_sets=1, wr_ready=1 → alu_start cycles 1..23; addr_serial_num 0..7 then holds 7; sram_write_enable cycles 24..38 with matrix_index 0..14; tpu_done at 39; data_set=0.
- Four sets → addr bases 0,8,16,24; data_set 0,1,2,0; tpu_done at cycle 153.
- Backpressure: wr_ready=0 for 3 cycles while matrix_index=5 → enable low and index held at 5 for those cycles; tpu_done delayed by exactly 3.
- Range limits: num_sets=16 → legal, last base 120, done at 609; num_sets=17 → cfg_err and tpu_done at cycle 1, alu_start never asserted.
- Abort/reset: abort at cycle 10 (COMPUTE) → busy=0 at 11 and no tpu_done; new start at 12 runs normally. srst during WRITE → all outputs 0 next cycle.
- num_sets=0 → tpu_done at cycle 1 with no cfg_err. tpu_start pulsed at cycle 5 while busy → ignored, timing unchanged.
